// File: rtl/hdlc_rx_channel.sv
// hdlc_rx_channel
// Serial front end of the HDLC receive path. Hunts for flags (01111110),
// removes stuffed zeros, detects aborts (seven ones) and assembles the
// destuffed bit stream LSB-first into bytes for the Rx frame buffer.
//
// Ports
//   Clk            system clock, rising edge
//   Rst            asynchronous reset, active low
//   Rx             serial receive line
//   RxEN           sample enable; when low all state holds
//   Rx_Data        last assembled byte (bit i = i-th received bit)
//   Rx_NewByte     pulse: Rx_Data updated
//   Rx_FlagDetect  pulse: flag seen
//   Rx_AbortDetect pulse: abort inside a valid frame
//   Rx_ValidFrame  level: frame data being received
//   Rx_EoF         pulse: frame closed by a flag
//   Rx_FrameError  pulse with Rx_EoF when frame is not byte aligned
//   Rx_FrameSize   bytes in current/last frame, saturating at MAX_COUNT
//
// state    | meaning
// ST_IDLE  | hunting for a flag; data and aborts ignored
// ST_FRAME | synchronised; committing destuffed bits after each flag
module hdlc_rx_channel #(
  parameter int MAX_COUNT = 255
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       Rx,
  input  logic       RxEN,
  output logic [7:0] Rx_Data,
  output logic       Rx_NewByte,
  output logic       Rx_FlagDetect,
  output logic       Rx_AbortDetect,
  output logic       Rx_ValidFrame,
  output logic       Rx_EoF,
  output logic       Rx_FrameError,
  output logic [7:0] Rx_FrameSize
);

  typedef enum logic {ST_IDLE, ST_FRAME} state_t;

  localparam logic [7:0] MAX_SIZE = 8'(MAX_COUNT);

  state_t     state_q;
  logic [2:0] ones_q;
  logic [2:0] ones_inc;
  logic [2:0] ones_d;
  logic [6:0] pipe_q;
  logic [6:0] pipe_d;
  logic [2:0] fill_q;
  logic [6:0] sreg_q;
  logic [2:0] bitcnt_q;
  logic       is_flag;
  logic       is_stuff;
  logic       is_abort;
  logic       is_data;
  logic       commit_bit;

  always_comb begin
    ones_inc   = (ones_q == 3'd7) ? 3'd7 : ones_q + 3'd1;
    ones_d     = Rx ? ones_inc : 3'd0;
    is_flag    = !Rx && (ones_q == 3'd6);
    is_stuff   = !Rx && (ones_q == 3'd5) && (state_q == ST_FRAME);
    is_abort   = Rx && (ones_inc == 3'd7);
    is_data    = !is_flag && !is_stuff && !is_abort;
    // The 7-deep delay hides the first seven bits of a closing flag, so
    // those never reach the byte assembler.
    pipe_d     = {pipe_q[5:0], Rx};
    commit_bit = pipe_q[6];
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q        <= ST_IDLE;
      ones_q         <= 3'd0;
      pipe_q         <= 7'd0;
      fill_q         <= 3'd0;
      sreg_q         <= 7'd0;
      bitcnt_q       <= 3'd0;
      Rx_Data        <= 8'd0;
      Rx_NewByte     <= 1'b0;
      Rx_FlagDetect  <= 1'b0;
      Rx_AbortDetect <= 1'b0;
      Rx_ValidFrame  <= 1'b0;
      Rx_EoF         <= 1'b0;
      Rx_FrameError  <= 1'b0;
      Rx_FrameSize   <= 8'd0;
    end else begin
      Rx_NewByte     <= 1'b0;
      Rx_FlagDetect  <= 1'b0;
      Rx_AbortDetect <= 1'b0;
      Rx_EoF         <= 1'b0;
      Rx_FrameError  <= 1'b0;
      if (RxEN) begin
        ones_q <= ones_d;
        case (state_q)
          ST_IDLE: begin
            if (is_flag) begin
              Rx_FlagDetect <= 1'b1;
              state_q       <= ST_FRAME;
              fill_q        <= 3'd0;
              bitcnt_q      <= 3'd0;
            end
          end
          ST_FRAME: begin
            if (is_flag) begin
              Rx_FlagDetect <= 1'b1;
              fill_q        <= 3'd0;
              bitcnt_q      <= 3'd0;
              if (Rx_ValidFrame) begin
                Rx_EoF        <= 1'b1;
                Rx_FrameError <= (bitcnt_q != 3'd0);
                Rx_ValidFrame <= 1'b0;
              end
            end else if (is_abort) begin
              state_q        <= ST_IDLE;
              fill_q         <= 3'd0;
              bitcnt_q       <= 3'd0;
              Rx_FrameSize   <= 8'd0;
              Rx_AbortDetect <= Rx_ValidFrame;
              Rx_ValidFrame  <= 1'b0;
            end else if (is_data) begin
              pipe_q <= pipe_d;
              if (fill_q != 3'd7) begin
                fill_q <= fill_q + 3'd1;
              end else begin
                // First commit after a flag opens the frame; the size of the
                // previous frame stays visible until this point.
                if (!Rx_ValidFrame) begin
                  Rx_ValidFrame <= 1'b1;
                  Rx_FrameSize  <= 8'd0;
                end
                if (bitcnt_q == 3'd7) begin
                  Rx_Data    <= {commit_bit, sreg_q};
                  Rx_NewByte <= 1'b1;
                  bitcnt_q   <= 3'd0;
                  if (Rx_FrameSize != MAX_SIZE) begin
                    Rx_FrameSize <= Rx_FrameSize + 8'd1;
                  end
                end else begin
                  sreg_q   <= {commit_bit, sreg_q[6:1]};
                  bitcnt_q <= bitcnt_q + 3'd1;
                end
              end
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hdlc_rx_channel.sv
module tb_hdlc_rx_channel;

  logic       Clk;
  logic       Rst;
  logic       Rx;
  logic       RxEN;
  logic [7:0] Rx_Data;
  logic       Rx_NewByte;
  logic       Rx_FlagDetect;
  logic       Rx_AbortDetect;
  logic       Rx_ValidFrame;
  logic       Rx_EoF;
  logic       Rx_FrameError;
  logic [7:0] Rx_FrameSize;

  hdlc_rx_channel #(.MAX_COUNT(255)) dut (
    .Clk            (Clk),
    .Rst            (Rst),
    .Rx             (Rx),
    .RxEN           (RxEN),
    .Rx_Data        (Rx_Data),
    .Rx_NewByte     (Rx_NewByte),
    .Rx_FlagDetect  (Rx_FlagDetect),
    .Rx_AbortDetect (Rx_AbortDetect),
    .Rx_ValidFrame  (Rx_ValidFrame),
    .Rx_EoF         (Rx_EoF),
    .Rx_FrameError  (Rx_FrameError),
    .Rx_FrameSize   (Rx_FrameSize)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic       err;
    logic [7:0] size;
    logic       chk_lat;
  } eof_t;

  logic [7:0] exp_bytes[$];
  eof_t       exp_eof[$];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int smp = 0;
  int byte_smp = 0;
  int byte_cyc = 0;
  int eof_cyc = 0;
  int abort_cyc = 0;
  int n_flag = 0;
  int n_eof = 0;
  int n_abort = 0;
  int n_valid = 0;
  int last_drive_cyc = 0;
  int tx_ones = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Monitor / scoreboard: sample 1 time unit after each rising edge.
  always @(posedge Clk) begin
    eof_t e;
    #1;
    cyc++;
    if (RxEN && Rst) smp++;
    if (Rx_FlagDetect) n_flag++;
    if (Rx_ValidFrame) n_valid++;
    if (Rx_NewByte) begin
      check("byte_expected", exp_bytes.size() != 0, 1);
      if (exp_bytes.size() != 0) check("rx_data", Rx_Data, exp_bytes.pop_front());
      check("valid_at_byte", Rx_ValidFrame, 1);
      byte_smp = smp;
      byte_cyc = cyc;
    end
    if (Rx_EoF) begin
      n_eof++;
      eof_cyc = cyc;
      check("eof_expected", exp_eof.size() != 0, 1);
      if (exp_eof.size() != 0) begin
        e = exp_eof.pop_front();
        check("frame_error", Rx_FrameError, e.err);
        check("frame_size", Rx_FrameSize, e.size);
        if (e.chk_lat) check("eof_latency", smp - byte_smp, 1);
      end
      check("valid_drop_at_eof", Rx_ValidFrame, 0);
    end
    if (Rx_AbortDetect) begin
      n_abort++;
      abort_cyc = cyc;
      check("valid_drop_at_abort", Rx_ValidFrame, 0);
    end
  end

  task automatic send_bit(input logic b);
    @(negedge Clk);
    Rx   = b;
    RxEN = 1'b1;
    last_drive_cyc = cyc + 1;
    tx_ones = b ? tx_ones + 1 : 0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge Clk);
      RxEN = 1'b0;
      Rx   = 1'($urandom);
    end
  endtask

  task automatic send_flag();
    send_bit(1'b0);
    repeat (6) send_bit(1'b1);
    send_bit(1'b0);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap_at);
    exp_bytes.push_back(b);
    for (int i = 0; i < 8; i++) begin
      send_bit(b[i]);
      if (tx_ones == 5) send_bit(1'b0);
      if (i == gap_at) idle(5);
    end
  endtask

  task automatic push_eof(input logic err, input logic [7:0] size, input logic lat);
    eof_t e;
    e.err = err;
    e.size = size;
    e.chk_lat = lat;
    exp_eof.push_back(e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int first_edge;
    int f0, e0, a0, v0;
    int nb6, ab7;

    Rst = 1'b0; Rx = 1'b1; RxEN = 1'b0;
    #1;
    check("rst_data", Rx_Data, 0);
    check("rst_newbyte", Rx_NewByte, 0);
    check("rst_flag", Rx_FlagDetect, 0);
    check("rst_abort", Rx_AbortDetect, 0);
    check("rst_valid", Rx_ValidFrame, 0);
    check("rst_eof", Rx_EoF, 0);
    check("rst_ferr", Rx_FrameError, 0);
    check("rst_size", Rx_FrameSize, 0);
    repeat (3) @(negedge Clk);
    Rst = 1'b1;
    idle(2);

    // Single frame, continuous enable
    f0 = n_flag;
    send_flag();
    first_edge = last_drive_cyc - 7;
    send_byte(8'hA5, -1);
    send_byte(8'h3C, -1);
    push_eof(1'b0, 8'd2, 1'b1);
    send_flag();
    idle(3);
    check("single_eof_time", eof_cyc - first_edge, 31);
    check("single_flags", n_flag - f0, 2);

    // Same frame with a 5-cycle enable gap in the middle of the second byte
    send_flag();
    first_edge = last_drive_cyc - 7;
    send_byte(8'hA5, -1);
    send_byte(8'h3C, 3);
    push_eof(1'b0, 8'd2, 1'b1);
    send_flag();
    idle(3);
    check("gap_eof_time", eof_cyc - first_edge, 36);

    // Stuffed zero removal
    send_flag();
    send_byte(8'hFF, -1);
    push_eof(1'b0, 8'd1, 1'b1);
    send_flag();
    idle(2);

    // Misaligned frame
    send_flag();
    send_byte(8'hA5, -1);
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    push_eof(1'b1, 8'd1, 1'b0);
    send_flag();
    idle(2);

    // Abort after a complete byte, then a clean restart
    e0 = n_eof; a0 = n_abort;
    nb6 = 0; ab7 = 0;
    send_flag();
    send_byte(8'h12, -1);
    send_bit(1'b0);
    for (int i = 1; i <= 8; i++) begin
      send_bit(1'b1);
      if (i == 6) nb6 = last_drive_cyc;
      if (i == 7) ab7 = last_drive_cyc;
    end
    idle(2);
    check("abort_count", n_abort - a0, 1);
    check("abort_time", abort_cyc, ab7);
    check("abort_byte_time", byte_cyc, nb6);
    check("abort_no_eof", n_eof - e0, 0);
    check("abort_valid", Rx_ValidFrame, 0);
    send_flag();
    send_byte(8'h77, -1);
    push_eof(1'b0, 8'd1, 1'b1);
    send_flag();
    idle(2);

    // Idle-high line and flag fill
    f0 = n_flag; e0 = n_eof; a0 = n_abort; v0 = n_valid;
    repeat (20) send_bit(1'b1);
    send_flag(); send_flag(); send_flag();
    repeat (20) send_bit(1'b1);
    idle(2);
    check("fill_flags", n_flag - f0, 3);
    check("fill_eof", n_eof - e0, 0);
    check("fill_abort", n_abort - a0, 0);
    check("fill_valid", n_valid - v0, 0);

    // Asynchronous reset mid-frame
    e0 = n_eof; a0 = n_abort;
    send_flag();
    send_byte(8'h5A, -1);
    for (int i = 0; i < 7; i++) send_bit(1'b0);
    @(posedge Clk);
    #2;
    check("pre_rst_valid", Rx_ValidFrame, 1);
    check("pre_rst_data", Rx_Data, 8'h5A);
    check("pre_rst_size", Rx_FrameSize, 1);
    #1;
    Rst = 1'b0;
    #1;
    check("arst_data", Rx_Data, 0);
    check("arst_valid", Rx_ValidFrame, 0);
    check("arst_size", Rx_FrameSize, 0);
    check("arst_newbyte", Rx_NewByte, 0);
    RxEN = 1'b0;
    repeat (2) @(negedge Clk);
    Rst = 1'b1;
    tx_ones = 0;
    idle(2);
    check("arst_no_eof", n_eof - e0, 0);
    check("arst_no_abort", n_abort - a0, 0);
    send_flag();
    send_byte(8'hC3, -1);
    send_byte(8'h81, -1);
    push_eof(1'b0, 8'd2, 1'b1);
    send_flag();
    idle(4);

    check("bytes_left", exp_bytes.size(), 0);
    check("eofs_left", exp_eof.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/hdlc_rx_channel.md
Name: hdlc_rx_channel

Overview:
- Serial front end of the HDLC receive path. Sits between the Rx line and the Rx frame buffer/register block.
- Hunts for flags (01111110), removes stuffed zeros, and detects aborts (seven consecutive ones).
- Assembles the destuffed bits LSB-first into bytes and reports frame boundaries, frame length and framing errors to the downstream buffer.

Parameters:
- MAX_COUNT, 255: saturation value of Rx_FrameSize; Rx_FrameSize width is 8 bits.

Ports:
- Clk  in  1  system clock; all state updates on the rising edge.
- Rst  in  1  asynchronous, active-low reset.
- Rx  in  1  serial receive line, one bit per enabled clock.
- RxEN  in  1  sample enable; when 0, Rx is ignored and all state holds.
- Rx_Data  out  8  last assembled byte; bit i is the i-th received bit.
- Rx_NewByte  out  1  one-cycle pulse: Rx_Data updated.
- Rx_FlagDetect  out  1  one-cycle pulse on every detected flag.
- Rx_AbortDetect  out  1  one-cycle pulse: abort inside a valid frame.
- Rx_ValidFrame  out  1  level: frame data is being received.
- Rx_EoF  out  1  one-cycle pulse: frame closed by a flag.
- Rx_FrameError  out  1  one-cycle pulse coincident with Rx_EoF when the frame is not byte-aligned.
- Rx_FrameSize  out  8  bytes in current/last frame, saturating at MAX_COUNT.

Behaviour:
- Reset: all outputs 0. State IDLE. Ones counter, pipeline fill, bit counter and byte counter all 0.
- Sample edge: a rising Clk edge with RxEN=1. All outputs are registered and change only on sample edges. Pulses last one clock. With RxEN=0, pulses deassert and everything else holds.
- Ones counter: increments on Rx=1 (saturating at 7); clears on Rx=0.
- Classification of a sampled 0 by the ones count before the sample:
  - count 6: flag.
  - count 5: stuffed zero, discarded (FRAME only).
  - otherwise: data bit.
- Classification of a sampled 1: data bit when the count after the sample is at most 6; abort condition when it reaches 7.
- Destuffed data bits enter a 7-deep delay pipeline. A bit leaving the pipeline (fill = 7) is committed into the byte shift register. Committing is done only in FRAME.
- The 8th committed bit completes a byte: Rx_Data loaded, Rx_NewByte pulses, Rx_FrameSize increments (saturating), bit counter wraps to 0.
- Latency: the last data byte of a frame commits on the edge sampling the sixth 1 of the closing flag. Rx_EoF follows on the next sample edge.
- States:
  - IDLE: hunt. A flag pulses Rx_FlagDetect and moves to FRAME.
  - FRAME:
    - On any flag: Rx_FlagDetect pulses; pipeline flushed (fill=0); bit counter cleared; stays in FRAME.
    - If Rx_ValidFrame was 1 at that flag: Rx_EoF pulses; Rx_FrameError = (bit counter != 0); Rx_ValidFrame drops.
    - Rx_FrameSize clears at the first committed bit after a flag, so it holds the last frame size until the next frame.
  - Abort condition in FRAME: go to IDLE, flush the pipeline and clear the counters. Rx_AbortDetect pulses only if Rx_ValidFrame=1; Rx_ValidFrame drops; no Rx_EoF.
  - Abort condition in IDLE: no effect, so an idle-high line is silent.
- Rx_ValidFrame rises on the edge committing the first data bit after a flag. Flag fill and shared flags therefore never raise it.
- Flag with zero bits committed (back-to-back flags): Rx_FlagDetect only; no Rx_EoF, no error.
- Flag and a completed byte can never coincide: at least one non-commit sample separates them.
- Asynchronous reset mid-frame: immediate return to the reset state; no Rx_EoF or Rx_AbortDetect is generated.

Test Plan:
- Single frame: flag, 0xA5, 0x3C, flag (LSB first) with RxEN=1 → Rx_NewByte with Rx_Data=0xA5, then 0x3C; Rx_EoF one cycle after the second Rx_NewByte; Rx_FrameError=0; Rx_FrameSize=2; Rx_ValidFrame high from first data bit to Rx_EoF.
- Stuffing: flag, bits 1,1,1,1,1,0,1,1,1, flag → one byte 0xFF; Rx_FrameSize=1; no error.
- Abort: flag, 0x12, then eight 1s → Rx_NewByte 0x12; Rx_AbortDetect on the 7th one; Rx_ValidFrame=0; no Rx_EoF; a later flag restarts cleanly.
- Misalignment: flag, 0xA5, bits 0,1,0, flag → Rx_EoF with Rx_FrameError=1; Rx_FrameSize=1.
- Flag fill and idle: line high for 20 bits, then flag, flag, flag, then high → three Rx_FlagDetect pulses; no Rx_EoF, Rx_ValidFrame or Rx_AbortDetect.
- RxEN gaps and reset: drop RxEN for 5 cycles mid-byte in the single-frame case → identical bytes, outputs delayed by 5 cycles. Assert Rst mid-frame → all outputs 0 asynchronously; the next frame decodes correctly.
